// File: rtl/ide_cycle_sequencer.sv
// ide_cycle_sequencer: runs 68000 cycles that hit the card window onto the IDE drive or autoboot ROM.
// Latency: CS after start edge; strobe SETUP_CYCLES later; dtack STROBE_CYCLES after that (ROM read: ROM_CYCLES).
// Backpressure: the host holds AS_n low until dtack; nothing is released until AS_n is seen high.
//
// Ports:
//   CLK, RESET_n           68000 bus clock, asynchronous active-low reset
//   ADDR[4:0]              host A16..A12; [4] region (0 ROM, 1 IDE), [0] CS1/CS0 select
//   AS_n, UDS_n, LDS_n, RW 68000 bus strobes and direction
//   ide_access             window hit from the Autoconfig decoder
//   IDE_CS0_n, IDE_CS1_n   drive chip selects
//   IDE_IOR_n, IDE_IOW_n   drive read/write strobes
//   IDE_RST_n              drive reset, stretched RST_EXTEND cycles past RESET_n
//   ROM_OE_n               autoboot ROM output enable
//   BUF_OE_n, BUF_DIR      data buffer enable and direction (1 = card drives host bus)
//   dtack, busy            acknowledge to host DTACK driver; sequencer not idle
module ide_cycle_sequencer #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned ROM_CYCLES    = 1,
  parameter int unsigned RST_EXTEND    = 8
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic [4:0] ADDR,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ide_access,
  output logic       IDE_CS0_n,
  output logic       IDE_CS1_n,
  output logic       IDE_IOR_n,
  output logic       IDE_IOW_n,
  output logic       IDE_RST_n,
  output logic       ROM_OE_n,
  output logic       BUF_OE_n,
  output logic       BUF_DIR,
  output logic       dtack,
  output logic       busy
);

  // A programmed 0 is treated as 1 so every phase lasts at least one clock.
  localparam logic [3:0] SETUP_LD  = (SETUP_CYCLES  == 0) ? 4'd1 : 4'(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LD = (STROBE_CYCLES == 0) ? 4'd1 : 4'(STROBE_CYCLES);
  localparam logic [3:0] HOLD_LD   = (HOLD_CYCLES   == 0) ? 4'd1 : 4'(HOLD_CYCLES);
  localparam logic [3:0] ROM_LD    = (ROM_CYCLES    == 0) ? 4'd1 : 4'(ROM_CYCLES);
  localparam logic [7:0] RST_LAST  = 8'(RST_EXTEND - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, HOLD, ROM} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lat_cs1;
  logic       lat_rw;
  logic       armed;
  logic [7:0] rst_cnt;
  logic       ide_rst_q;
  logic       take;
  logic       addr_unused;

  // A16 is only needed at the start decision; A15..A13 do not matter.
  assign addr_unused = ^ADDR[3:1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        // armed blocks a second start until AS_n has been seen high after the last one.
        if (ide_access && !AS_n && (!UDS_n || !LDS_n) && ide_rst_q && armed) begin
          take = 1'b1;
          if (ADDR[4]) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
          end else begin
            state_nxt = ROM;
            cnt_nxt   = RW ? ROM_LD : 4'd1;
          end
        end
      end
      SETUP: begin
        if (AS_n) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else if (cnt == 4'd1) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        // Abort wins over expiry so dtack is never shown to a host that has left.
        if (AS_n) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else if (cnt == 4'd1) begin
          state_nxt = ACK;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: begin
        if (AS_n) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ROM: begin
        // Count parks at 0, which is what raises dtack.
        if (AS_n) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_cs1   <= 1'b0;
      lat_rw    <= 1'b0;
      armed     <= 1'b1;
      rst_cnt   <= 8'd0;
      ide_rst_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        lat_cs1 <= ADDR[0];
        lat_rw  <= RW;
        armed   <= 1'b0;
      end else if (AS_n) begin
        armed <= 1'b1;
      end
      if (!ide_rst_q) begin
        if (rst_cnt == RST_LAST) ide_rst_q <= 1'b1;
        else                     rst_cnt   <= rst_cnt + 8'd1;
      end
    end
  end

  // Outputs decode straight from registered state so an async reset clears them at once.
  logic cs_on, stb_on, rom_rd;
  assign cs_on  = (state == SETUP) || (state == STROBE) || (state == ACK) || (state == HOLD);
  assign stb_on = (state == STROBE) || (state == ACK);
  assign rom_rd = (state == ROM) && lat_rw;

  assign IDE_CS0_n = !(cs_on && !lat_cs1);
  assign IDE_CS1_n = !(cs_on && lat_cs1);
  assign IDE_IOR_n = !(stb_on && lat_rw);
  assign IDE_IOW_n = !(stb_on && !lat_rw);
  assign IDE_RST_n = ide_rst_q;
  assign ROM_OE_n  = !rom_rd;
  assign BUF_OE_n  = !(cs_on || rom_rd);
  assign BUF_DIR   = cs_on ? lat_rw : rom_rd;
  assign dtack     = (state == ACK) || ((state == ROM) && (cnt == 4'd0));
  assign busy      = (state != IDLE);

endmodule
